// File: rtl/seq_det_ctrl_if.sv
// Word-input handshake between the datapath (master) and the sequence
// detector controller (slave).
interface seq_det_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// Word-level controller for a bit-serial 1011 detector: shifts accepted words
// MSB-first into the detector and reports match pulses, positions and a count.
module seq_det_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_det_ctrl_if.slave    in_if,
  input  logic             clear_i,
  output logic             det_x_o,
  output logic             det_rst_o,
  input  logic             det_z_i,
  output logic             match_pulse_o,
  output logic [POS_W-1:0] match_pos_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             done_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [POS_W-1:0] bitcnt_q, bitcnt_d;
  logic             pulse_q, pulse_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_c;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    pulse_d    = 1'b0;
    pos_d      = pos_q;
    count_d    = count_q;
    in_ready_c = 1'b0;
    det_rst_o  = 1'b1;
    det_x_o    = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b1;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_o     = 1'b0;
        if (in_if.in_valid) begin
          shreg_d  = in_if.in_data;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        det_rst_o = 1'b0;
        det_x_o   = shreg_q[WIDTH-1];
        // det_z is Mealy: it reflects the bit being driven in this very cycle.
        if (det_z_i) begin
          pulse_d = 1'b1;
          pos_d   = bitcnt_q;
          if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
        end
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + POS_W'(1);
        if (bitcnt_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear beats a same-edge increment; pulse and position still report.
    if (clear_i) count_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      pulse_q  <= 1'b0;
      pos_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      pulse_q  <= pulse_d;
      pos_q    <= pos_d;
      count_q  <= count_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign match_pulse_o  = pulse_q;
  assign match_pos_o    = pos_q;
  assign match_count_o  = count_q;

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-level controller for the serial 1011 overlapping sequence detector. It accepts parallel words over a valid/ready handshake and shifts them MSB-first into the detector, one bit per clock. It resets the detector between words, samples its match output, and reports match events, bit positions and a saturating match count. It sits between the word-oriented datapath and the bit-serial detector instance, which it drives directly.

## Interface
- WIDTH, 8: bits per input word; at least 2.
- CNT_W, 8: width of match_count.
- POS_W, $clog2(WIDTH): width of match_pos.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; one clock only.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is scanned first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a word.
- clear  in  1  synchronous; zeroes match_count.
- det_x  out  1  serial bit to detector x.
- det_rst  out  1  to detector reset (active-high, synchronous).
- det_z  in  1  detector z (Mealy; combinational from detector state and det_x).
- match_pulse  out  1  one-cycle pulse per detected match.
- match_pos  out  POS_W  bit index of the match within the word (0 = MSB, first bit scanned).
- match_count  out  CNT_W  saturating total of matches.
- done  out  1  one-cycle pulse when a word has been fully scanned.
- busy  out  1  high in SHIFT and DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1 and det_rst=1.
  - On in_valid&in_ready: load the shift register with in_data, set bitcnt=0, go to SHIFT.
- SHIFT:
  - det_rst=0; det_x is the shift-register MSB.
  - At each edge: if det_z=1, register match_pulse=1, match_pos=bitcnt and match_count+1 (saturating at 2^CNT_W-1).
  - At the same edge: shift left by one, bitcnt+1.
  - When bitcnt==WIDTH-1 at the edge, go to DONE.
- DONE: det_rst=1, done=1 for one cycle, then IDLE.
- det_rst=1 in IDLE and DONE, so detector history never spans words. A pattern straddling two words is not detected.
- clear: zeroes match_count at the next edge in any state. It wins over a same-edge increment; match_pulse and match_pos are still reported.
- match_pos holds its last value until the next match.
- Reset assertion at any time:
  - state=IDLE, the in-flight word is discarded, no done pulse.
  - All registers clear. det_rst=1 (combinational from IDLE).

## Timing
- Reset values:
  - in_ready=1, det_rst=1, busy=0.
  - det_x=0, match_pulse=0, match_pos=0, match_count=0, done=0.
  - in_valid is ignored while reset is low.
- Accept edge E0: SHIFT cycles 1..WIDTH drive bit WIDTH-i in cycle i. DONE is cycle WIDTH+1; IDLE is cycle WIDTH+2.
- match_pulse is registered. It is high in the cycle after the SHIFT cycle whose bit completed the pattern. A match on the last bit pulses during DONE.
- Throughput: one word per WIDTH+2 cycles. in_ready is low in SHIFT and DONE, so in_valid may stay high and the next word is accepted on the first IDLE edge.
- in_data is captured at the accept edge only; later changes have no effect.

## Test plan
- Reset release, then in_data=8'hB6 with in_valid=1 -> matches at pos 3 and 6, in cycles 5 and 8 after accept. done in cycle 9, match_count=2, in_ready back high in cycle 10.
- 8'hFF, then 8'h00 -> no match_pulse, match_count stays 0, two done pulses 10 cycles apart.
- 8'h05 then 8'h80 back-to-back (boundary pattern 1011) -> no match (det_rst between words). 8'hAD -> one match at pos 5.
- CNT_W=2, four 8'hB6 words -> match_count saturates at 3; match_pulse still fires for all 8 matches.
- clear asserted on the edge where the match at pos 6 of 8'hB6 registers -> match_count=0 after that edge, match_pulse=1 with match_pos=6.
- reset pulled low mid-SHIFT (cycle 4 of 8'hB6) -> immediate IDLE outputs, count 0, no done. A fresh 8'hB6 after release scans normally.
